// File: rtl/aibcr3_ddr_deser_if.sv
// Bus bundle for the DDR deserializer.
//   din       : DDR serial stream (bit A in clk-high phase, bit B in clk-low phase)
//   rx_en     : receive enable
//   bitslip   : one-cycle request to move the word boundary by one serial bit
//   dout      : assembled parallel word, dout[0] is the earliest bit
//   dout_vld  : one-cycle strobe marking a new dout
//   slip_busy : high while a bitslip is being applied
// master = stream source / consumer side, slave = the deserializer.
interface aibcr3_ddr_deser_if #(
    parameter int DWIDTH = 8
) ();
    logic              din;
    logic              rx_en;
    logic              bitslip;
    logic [DWIDTH-1:0] dout;
    logic              dout_vld;
    logic              slip_busy;

    modport master (output din, rx_en, bitslip, input dout, dout_vld, slip_busy);
    modport slave  (input din, rx_en, bitslip, output dout, dout_vld, slip_busy);
endinterface

// File: rtl/aibcr3_ddr_deser.sv
// DDR serial-to-parallel receiver with bitslip alignment.
// Ports:
//   clk  : single clock, din sampled on both edges
//   rst  : asynchronous active-high reset
//   bus  : aibcr3_ddr_deser_if.slave (din, rx_en, bitslip in; dout, dout_vld, slip_busy out)
// DWIDTH must be even, 4..64. Two serial bits are taken per clk cycle and
// shifted into an assembly register; a full word is published on dout with
// a one-cycle dout_vld strobe.
module aibcr3_ddr_deser #(
    parameter int DWIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    aibcr3_ddr_deser_if.slave bus
);
    localparam int NPAIR = DWIDTH / 2;
    localparam int CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPAIR - 1);

    logic              fbit;        // falling-edge capture: high-phase bit f_n
    logic              rbit;        // rising-edge capture of din
    logic              rprev;       // r_{n-1} as seen at rising edge n
    logic              odd;         // 1: pairs straddle the clk cycle boundary
    logic              pend;        // discard the next pair (slip taken on a completion edge)
    logic              busy_tail;
    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] asm_q;
    logic [DWIDTH-1:0] dout_q;
    logic              dout_vld_q;
    logic              slip_busy_q;

    logic              slip_ok;
    logic              at_last;
    logic              take;
    logic              early;
    logic              late;
    logic [DWIDTH-1:0] word;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) fbit <= 1'b0;
        else     fbit <= bus.din;
    end

    // rbit is loaded with r_n at edge n, so before that edge it still holds
    // r_{n-1}; the current low-phase bit r_n is taken straight from din.
    assign rprev   = rbit;

    assign slip_ok = bus.bitslip & bus.rx_en & ~slip_busy_q;
    assign at_last = (cnt == LAST);
    assign early   = odd ? rprev : fbit;
    assign late    = odd ? fbit  : bus.din;

    // A slip from even alignment normally eats the current pair; on a
    // completion edge the word is finished first and the following pair
    // is eaten instead (pend).
    assign take    = bus.rx_en & ~pend & ~(slip_ok & ~odd & ~at_last);

    // New pair enters at the top; after NPAIR pairs the first one sits at [1:0].
    assign word    = {late, early, asm_q[DWIDTH-1:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbit        <= 1'b0;
            odd         <= 1'b0;
            pend        <= 1'b0;
            busy_tail   <= 1'b0;
            cnt         <= '0;
            asm_q       <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            slip_busy_q <= 1'b0;
        end else begin
            rbit       <= bus.din;
            dout_vld_q <= 1'b0;

            if (!bus.rx_en) begin
                // partial word is dropped; alignment (odd) is kept
                cnt  <= '0;
                pend <= 1'b0;
            end else begin
                if (pend) pend <= 1'b0;
                if (slip_ok) begin
                    odd <= ~odd;
                    if (~odd & at_last) pend <= 1'b1;
                end
                if (take) begin
                    asm_q <= word;
                    if (at_last) begin
                        dout_q     <= word;
                        dout_vld_q <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            // slip_busy covers the two cycles after an accepted slip
            if (slip_ok) begin
                slip_busy_q <= 1'b1;
                busy_tail   <= 1'b1;
            end else begin
                slip_busy_q <= busy_tail;
                busy_tail   <= 1'b0;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.slip_busy = slip_busy_q;
endmodule

// File: tb/tb_aibcr3_ddr_deser.sv
// Bench for aibcr3_ddr_deser: hand-built vector table, targeted corner
// sequences and a randomized run, all checked every cycle against a
// stream-position reference model.
module tb_aibcr3_ddr_deser;
    localparam int DW = 8;
    localparam int NP = DW / 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    aibcr3_ddr_deser_if #(.DWIDTH(DW)) bus ();

    aibcr3_ddr_deser #(.DWIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial stream by global bit index: edge e owns bits 2e (high phase)
    // and 2e+1 (low phase). Bits of cycles spent in reset read as 0.
    bit            sbit [0:8191];
    int            ecount;

    // Reference model state
    bit            m_odd;
    bit            m_pend;
    int            m_busy;
    int            m_cnt;
    logic [DW-1:0] m_word;
    logic [DW-1:0] m_dout;
    bit            m_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    task automatic model_reset();
        m_odd = 0; m_pend = 0; m_busy = 0; m_cnt = 0;
        m_word = '0; m_dout = '0; m_vld = 0;
    endtask

    // One rising edge of the receiver, expressed as "which two stream bits
    // are available and whether they are kept".
    task automatic model_edge(input logic rx, input logic bs);
        bit slip, tk;
        int w;
        m_vld = 0;
        slip  = bs && rx && (m_busy == 0);
        if (!rx) begin
            m_cnt  = 0;
            m_pend = 0;
        end else begin
            w  = 2 * ecount - int'(m_odd);
            tk = 1;
            if (m_pend) begin
                tk = 0;
                m_pend = 0;
            end else if (slip && !m_odd) begin
                if (m_cnt == NP - 1) m_pend = 1;
                else                 tk = 0;
            end
            if (tk) begin
                m_word[2*m_cnt]   = sbit[w];
                m_word[2*m_cnt+1] = sbit[w+1];
                if (m_cnt == NP - 1) begin
                    m_dout = m_word;
                    m_vld  = 1;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (slip) m_odd = !m_odd;
        end
        if (slip)            m_busy = 2;
        else if (m_busy > 0) m_busy--;
    endtask

    task automatic model_check();
        chk("model_dout", bus.dout, m_dout);
        chk("model_vld", bus.dout_vld, m_vld);
        chk("model_busy", bus.slip_busy, (m_busy > 0));
    endtask

    // Called just after a rising edge; drives one clk cycle and returns #1
    // after the next rising edge with the model advanced and compared.
    task automatic step(input logic r, input logic rx, input logic bs, input logic a, input logic b);
        rst         = r;
        bus.rx_en   = rx;
        bus.bitslip = bs;
        bus.din     = a;
        @(negedge clk);
        #1 bus.din  = b;
        @(posedge clk);
        ecount++;
        sbit[2*ecount]   = r ? 1'b0 : a;
        sbit[2*ecount+1] = r ? 1'b0 : b;
        if (r) model_reset();
        else   model_edge(rx, bs);
        #1;
        model_check();
    endtask

    // Reset for one cycle; outputs must clear as soon as rst rises.
    task automatic reset_step();
        rst         = 1'b1;
        bus.rx_en   = 1'b0;
        bus.bitslip = 1'b0;
        bus.din     = 1'b0;
        #1;
        chk("rst_dout", bus.dout, '0);
        chk("rst_vld", bus.dout_vld, 1'b0);
        chk("rst_busy", bus.slip_busy, 1'b0);
        @(posedge clk);
        ecount++;
        sbit[2*ecount]   = 1'b0;
        sbit[2*ecount+1] = 1'b0;
        model_reset();
        #1;
        model_check();
    endtask

    typedef struct {
        logic          rx;
        logic          bs;
        logic          a;
        logic          b;
        logic [DW-1:0] dout;
        logic          vld;
        logic          busy;
    } vec_t;

    vec_t tbl [12];

    initial begin : main
        logic [7:0] w;
        bit         bits [$];
        int         busy_n;
        int         strobes;
        bit         seen;

        total = 0; bad = 0; ecount = 0;
        rst = 1'b1;
        bus.din = 1'b0; bus.rx_en = 1'b0; bus.bitslip = 1'b0;
        model_reset();

        // 0xA5 LSB-first, strobe on every 4th pair
        w = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            tbl[i].rx   = 1'b1;
            tbl[i].bs   = 1'b0;
            tbl[i].a    = w[2*(i%4)];
            tbl[i].b    = w[2*(i%4)+1];
            tbl[i].dout = (i < 3) ? 8'h00 : 8'hA5;
            tbl[i].vld  = ((i % 4) == 3);
            tbl[i].busy = 1'b0;
        end

        @(posedge clk); #1;
        reset_step();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].rx, tbl[i].bs, tbl[i].a, tbl[i].b);
            chk("tbl_dout", bus.dout, tbl[i].dout);
            chk("tbl_vld", bus.dout_vld, tbl[i].vld);
            chk("tbl_busy", bus.slip_busy, tbl[i].busy);
        end

        // one extra leading bit, then a single slip realigns to 0xA5
        reset_step();
        bits.delete();
        bits.push_back(1'b1);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        busy_n = 0; strobes = 0;
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 1'b1, (s == 1), bits[2*s], bits[2*s+1]);
            if (bus.slip_busy) busy_n++;
            if (bus.dout_vld) begin
                strobes++;
                if (strobes >= 2) chk("slip_settle", bus.dout, 8'hA5);
            end
        end
        chk("slip_busy_len", busy_n, 2);
        chk("slip_strobes", strobes, 3);

        // back-to-back slips: second one lands in the busy window
        reset_step();
        busy_n = 0;
        for (int s = 0; s < 12; s++) begin
            step(1'b0, 1'b1, (s == 1 || s == 2), 1'($urandom), 1'($urandom));
            if (bus.slip_busy) busy_n++;
        end
        chk("double_slip_busy", busy_n, 2);

        // rx_en dropped after 2 pairs, then a fresh word
        reset_step();
        strobes = 0;
        for (int s = 0; s < 2; s++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            if (bus.dout_vld) strobes++;
        end
        for (int s = 0; s < 2; s++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            if (bus.dout_vld) strobes++;
        end
        chk("partial_no_strobe", strobes, 0);
        w = 8'h3C;
        for (int s = 0; s < 4; s++) begin
            step(1'b0, 1'b1, 1'b0, w[2*s], w[2*s+1]);
            if (bus.dout_vld) strobes++;
        end
        chk("rx_rise_word", bus.dout, 8'h3C);
        chk("rx_rise_strobes", strobes, 1);

        // reset mid-word and mid-slip
        reset_step();
        w = 8'hA5;
        for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 1'b0, w[2*s], w[2*s+1]);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_busy", bus.slip_busy, 1'b1);
        reset_step();
        w = 8'h5A;
        strobes = 0;
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b1, 1'b0, w[2*s], w[2*s+1]);
            if (bus.dout_vld) strobes++;
        end
        chk("post_rst_early_strobe", strobes, 0);
        step(1'b0, 1'b1, 1'b0, w[6], w[7]);
        chk("post_rst_word", bus.dout, 8'h5A);
        chk("post_rst_vld", bus.dout_vld, 1'b1);

        // slip on the completion edge
        reset_step();
        w = 8'hA5;
        for (int s = 0; s < 4; s++) step(1'b0, 1'b1, (s == 3), w[2*s], w[2*s+1]);
        chk("cmpl_slip_word", bus.dout, 8'hA5);
        chk("cmpl_slip_vld", bus.dout_vld, 1'b1);
        seen = 0;
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b1, 1'b0, w[2*(s%4)], w[2*(s%4)+1]);
            if (bus.dout_vld && !seen) begin
                seen = 1;
                chk("cmpl_slip_next", bus.dout, 8'hD2);
            end
        end
        chk("cmpl_slip_next_seen", seen, 1'b1);

        // randomized run
        for (int s = 0; s < 600; s++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(9) != 0),
                 ($urandom_range(11) == 0),
                 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aibcr3_ddr_deser.md
AIBCR3_DDR_DESER -- requirements
Module: aibcr3_ddr_deser

Interface
REQ-001 Parameter DWIDTH, default 8, SHALL set the parallel word width; legal values are even and 4..64.
REQ-002 clk  input  1  SHALL be the single clock; DDR data SHALL be sampled on both edges of clk.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 din  input  1  SHALL carry the DDR serial stream: bit A valid in the clk-high phase, bit B valid in the clk-low phase, matching the companion ddrmux transmitter.
REQ-005 rx_en  input  1  SHALL be the receive enable, sampled on the rising edge.
REQ-006 bitslip  input  1  SHALL be a single-cycle request to shift the word boundary by one serial bit.
REQ-007 dout  output  DWIDTH  SHALL carry the assembled parallel word; dout[0] is the earliest-received bit.
REQ-008 dout_vld  output  1  SHALL be a one-cycle strobe marking a new dout.
REQ-009 slip_busy  output  1  SHALL be high while a bitslip is being applied.

Function
REQ-010 Falling-edge flop fbit SHALL capture din; rising-edge flop rbit SHALL capture din, so that at rising edge n: f_n is the earlier bit (high phase) and r_n is the later bit (low phase).
REQ-011 Register rprev SHALL hold r_{n-1}; register odd SHALL select alignment.
REQ-012 With odd=0, the pair taken at edge n SHALL be (f_n, r_n); with odd=1, it SHALL be (r_{n-1}, f_n), earlier bit first.
REQ-013 Each accepted pair SHALL shift into a DWIDTH-bit assembly register, 2 bits per cycle, earlier bit at the lower index of the pair.
REQ-014 A pair counter cnt, 0..DWIDTH/2-1, SHALL increment per accepted pair and wrap to 0.
REQ-015 On the edge where the pair accepted at cnt=DWIDTH/2-1 completes a word, dout SHALL load that word and dout_vld SHALL be 1 for exactly the next cycle.
REQ-016 Latency from the rising edge capturing the last pair to dout_vld=1 SHALL be 1 cycle.
REQ-017 dout SHALL hold its value between strobes.
REQ-018 With rx_en=0: cnt SHALL be forced to 0, no pair SHALL be accepted, dout_vld SHALL be 0, dout SHALL hold, and bitslip SHALL be ignored.
REQ-019 When rx_en rises, the first accepted pair SHALL be placed at word positions [1:0].
REQ-020 A bitslip is accepted when bitslip=1, rx_en=1 and slip_busy=0 at a rising edge E; it SHALL be ignored otherwise.
REQ-021 If accepted with odd=0, odd SHALL become 1, and the pair at E SHALL be discarded (cnt and assembly register hold).
REQ-022 If accepted with odd=1, odd SHALL become 0, and the pair at E SHALL be accepted normally with odd=1 alignment.
REQ-023 Either case SHALL drop exactly one serial bit from the assembled stream.
REQ-024 slip_busy SHALL be 1 for the 2 cycles following acceptance, then 0.
REQ-025 If a bitslip is accepted on the same edge as word completion, the word SHALL still be output; the discard (REQ-021) SHALL apply to the following pair.
REQ-026 If rx_en falls during a partial word, the partial word SHALL be discarded; odd SHALL be retained.

Reset
REQ-027 rst=1 SHALL immediately clear dout, dout_vld, slip_busy, cnt, odd, rprev, fbit, rbit and the assembly register to 0.
REQ-028 Reset asserted mid-word or mid-slip SHALL abort the operation, with no dout_vld pulse afterward until a full new word is assembled.
REQ-029 Release of rst is synchronised externally to clk; the block SHALL need no edge other than the first rising edge after release to resume.

Verification
REQ-030 DWIDTH=8, rx_en=1, serial stream 0xA5 repeated LSB-first -> dout=0xA5 with dout_vld every 4th cycle; first strobe 1 cycle after the 4th pair.
REQ-031 Stream 0xA5 LSB-first preceded by one extra leading bit, then one bitslip -> dout settles to 0xA5 within 2 words; slip_busy high for exactly 2 cycles.
REQ-032 Two bitslips back-to-back, with the second arriving while slip_busy=1 -> the second is ignored; odd toggles once.
REQ-033 rx_en dropped after 2 pairs, then raised -> no strobe for the partial word; next dout is built from pairs after the rise.
REQ-034 rst pulsed mid-word -> all outputs 0 immediately; the next dout_vld occurs only after 4 new pairs.
REQ-035 Bitslip on the completion edge -> the current word is output intact; the next word is shifted by one bit.
